// File: rtl/hazard_tnew_pipe_pkg.sv
`default_nettype none
// ============================================================================
// hazard_tnew_pipe_pkg
//   Shared types, T_use/T_new codes and forward-select encodings.
//   Revision: 1.0
// ============================================================================
package hazard_tnew_pipe_pkg;

  localparam int REG_W  = 5;
  localparam int TUSE_W = 3;
  localparam int TNEW_W = 2;
  localparam int SEL_W  = 2;

  localparam logic [TUSE_W-1:0] TUSE_NONE = 3'd4;

  localparam logic [SEL_W-1:0] FWD_RF = 2'd0;
  localparam logic [SEL_W-1:0] FWD_M  = 2'd1;
  localparam logic [SEL_W-1:0] FWD_W  = 2'd2;
  localparam logic [SEL_W-1:0] FWD_E  = 2'd3;

  localparam logic [TNEW_W-1:0] TNEW_ALU  = 2'd1;
  localparam logic [TNEW_W-1:0] TNEW_LOAD = 2'd2;
  localparam logic [TNEW_W-1:0] TNEW_LINK = 2'd0;

  typedef struct packed {
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  dst;
    logic [TNEW_W-1:0] tnew;
  } e_stage_t;

  typedef struct packed {
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  dst;
    logic [TNEW_W-1:0] tnew;
  } m_stage_t;

  // T_new counts down one per stage and parks at zero.
  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - 2'd1;
  endfunction

  function automatic logic tnew_blocks(input logic [REG_W-1:0]  dst,
                                       input logic [TNEW_W-1:0] tnew,
                                       input logic [REG_W-1:0]  src,
                                       input logic [TUSE_W-1:0] tuse);
    return (src != '0) && (dst == src) && (tuse != TUSE_NONE) && ({1'b0, tnew} > tuse);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_fwd_sel.sv
`default_nettype none
// ============================================================================
// hazard_fwd_sel
//   Youngest-match forward select for one source address over E/M/W.
//   Revision: 1.0
// ============================================================================
module hazard_fwd_sel
  import hazard_tnew_pipe_pkg::*;
(
  input  logic [REG_W-1:0]  i_src,
  input  logic [REG_W-1:0]  i_e_dst,
  input  logic [TNEW_W-1:0] i_e_tnew,
  input  logic [REG_W-1:0]  i_m_dst,
  input  logic [TNEW_W-1:0] i_m_tnew,
  input  logic [REG_W-1:0]  i_w_dst,
  output logic [SEL_W-1:0]  o_sel
);

  logic w_live;
  logic w_hit_e;
  logic w_hit_m;
  logic w_hit_w;

  assign w_live  = (i_src != '0);
  assign w_hit_e = w_live && (i_e_dst == i_src);
  assign w_hit_m = w_live && (i_m_dst == i_src);
  assign w_hit_w = w_live && (i_w_dst == i_src);

  // A younger match that is not ready yet masks every older stage.
  always_comb begin
    o_sel = FWD_RF;
    if (w_hit_e)      o_sel = (i_e_tnew == '0) ? FWD_E : FWD_RF;
    else if (w_hit_m) o_sel = (i_m_tnew == '0) ? FWD_M : FWD_RF;
    else if (w_hit_w) o_sel = FWD_W;
  end

endmodule
`default_nettype wire

// File: rtl/hazard_tnew_pipe.sv
`default_nettype none
// ============================================================================
// hazard_tnew_pipe
//   Tracks dst/T_new through E/M/W; produces stall and forward selects.
//   Revision: 1.0
// ============================================================================
module hazard_tnew_pipe
  import hazard_tnew_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  rs_d,
  input  logic [REG_W-1:0]  rt_d,
  input  logic [TUSE_W-1:0] tuse_rs_d,
  input  logic [TUSE_W-1:0] tuse_rt_d,
  input  logic [REG_W-1:0]  dst_d,
  input  logic [TNEW_W-1:0] tnew_d,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_rs_d,
  output logic [SEL_W-1:0]  fwd_rt_d,
  output logic [SEL_W-1:0]  fwd_rs_e,
  output logic [SEL_W-1:0]  fwd_rt_e,
  output logic              fwd_rt_m
);

  e_stage_t         r_e;
  m_stage_t         r_m;
  logic [REG_W-1:0] r_w_dst;
  logic [SEL_W-1:0] w_sel_rt_m;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_e     <= '0;
      r_m     <= '0;
      r_w_dst <= '0;
    end else begin
      r_w_dst <= r_m.dst;
      r_m     <= '{rt: r_e.rt, dst: r_e.dst, tnew: tnew_dec(r_e.tnew)};
      r_e     <= stall ? '0 : '{rs: rs_d, rt: rt_d, dst: dst_d, tnew: tnew_d};
    end
  end

  assign stall = tnew_blocks(r_e.dst, r_e.tnew, rs_d, tuse_rs_d)
               | tnew_blocks(r_e.dst, r_e.tnew, rt_d, tuse_rt_d)
               | tnew_blocks(r_m.dst, r_m.tnew, rs_d, tuse_rs_d)
               | tnew_blocks(r_m.dst, r_m.tnew, rt_d, tuse_rt_d);

  hazard_fwd_sel u_sel_rs_d (
    .i_src(rs_d), .i_e_dst(r_e.dst), .i_e_tnew(r_e.tnew),
    .i_m_dst(r_m.dst), .i_m_tnew(r_m.tnew), .i_w_dst(r_w_dst), .o_sel(fwd_rs_d)
  );

  hazard_fwd_sel u_sel_rt_d (
    .i_src(rt_d), .i_e_dst(r_e.dst), .i_e_tnew(r_e.tnew),
    .i_m_dst(r_m.dst), .i_m_tnew(r_m.tnew), .i_w_dst(r_w_dst), .o_sel(fwd_rt_d)
  );

  // Later stages only look downstream of themselves, so the E slot is tied off.
  hazard_fwd_sel u_sel_rs_e (
    .i_src(r_e.rs), .i_e_dst('0), .i_e_tnew('0),
    .i_m_dst(r_m.dst), .i_m_tnew(r_m.tnew), .i_w_dst(r_w_dst), .o_sel(fwd_rs_e)
  );

  hazard_fwd_sel u_sel_rt_e (
    .i_src(r_e.rt), .i_e_dst('0), .i_e_tnew('0),
    .i_m_dst(r_m.dst), .i_m_tnew(r_m.tnew), .i_w_dst(r_w_dst), .o_sel(fwd_rt_e)
  );

  hazard_fwd_sel u_sel_rt_m (
    .i_src(r_m.rt), .i_e_dst('0), .i_e_tnew('0),
    .i_m_dst('0), .i_m_tnew('0), .i_w_dst(r_w_dst), .o_sel(w_sel_rt_m)
  );

  assign fwd_rt_m = (w_sel_rt_m == FWD_W);

endmodule
`default_nettype wire
